imu_spi_responder: RTL
======================

# imu_spi_responder

SPI-mode-0 slave that emulates the IMU on the far end of the `jb_imu` link. It answers `jb_imu`'s frame-read command by shifting out nine 16-bit attitude/rate/acceleration words captured from parallel inputs. It sits in the simulation and hardware-in-the-loop harness in place of the physical IMU and also serves as a loopback target on the FPGA. All SPI inputs are asynchronous and are oversampled on `clock`.

## Interface

- `READ_CMD`, 8'h01: command byte that requests a telemetry frame.
- `SYNC_BYTE`, 8'hA5: byte returned on `miso` while the command byte is received.
- `clock`  in  1  system clock, 50 MHz nominal.
- `reset`  in  1  asynchronous, active-low reset; all state clears while `reset`=0.
- `roll`, `pitch`, `yaw`  in  16 each  attitude words.
- `roll_rate`, `pitch_rate`, `yaw_rate`  in  16 each  rate words.
- `accel_x`, `accel_y`, `accel_z`  in  16 each  acceleration words.
- `ss`  in  1  slave select, active-low, asynchronous.
- `sck`  in  1  SPI clock, CPOL=0; maximum frequency is `clock`/8.
- `mosi`  in  1  master-out data, MSB first.
- `miso`  out  1  slave-out data, MSB first.
- `miso_oe`  out  1  `miso` output enable; equals 1 while synchronized `ss`=0.
- `busy`  out  1  high whenever state ≠ IDLE.
- `frame_done`  out  1  one-cycle pulse when the last frame byte completes.
- `cmd_err`  out  1  one-cycle pulse when the command byte ≠ `READ_CMD`.
- `frame_abort`  out  1  one-cycle pulse when `ss` rises before the frame completes.

## Operation

- **Synchronizers.** `ss`, `sck` and `mosi` each pass through two flops and one extra history flop. Rise and fall of `sck` and `ss` are detected from the synchronized values.
- **States:** IDLE, CMD, DATA, CSUM (only with checksum), DRAIN.
- **IDLE.**
  - `miso`=0.
  - On synchronized `ss` falling: bit counter=0, load the TX shift register with `SYNC_BYTE`, drive its MSB, go to CMD.
- **Shifting rule, all active states.**
  - On `sck` rise: sample `mosi` into the RX shift register (MSB first), then increment the 3-bit bit counter (wraps 7→0).
  - On `sck` fall: shift TX left and drive the new MSB.
  - After the 8th rise (counter wraps), the next byte is loaded into TX, and its MSB is driven on the following `sck` fall.
- **CMD, at the 8th rise.**
  - If RX = `READ_CMD`: snapshot all nine inputs into a 144-bit shadow register, set byte counter=0, go to DATA.
  - Otherwise: pulse `cmd_err` and go to DRAIN.
- **DATA.**
  - Byte order: roll, pitch, yaw, roll_rate, pitch_rate, yaw_rate, accel_x, accel_y, accel_z, each high byte first, for 18 bytes.
  - The byte counter is 5 bits.
  - After byte 17 completes: go to CSUM if enabled; otherwise pulse `frame_done` and go to DRAIN.
- **DRAIN.**
  - `miso` outputs 8'h00 for every further byte.
  - `mosi` is ignored.
  - Stays in DRAIN until `ss` rises.
- **`ss` rise in any state:** return to IDLE and clear the counters. `frame_abort` pulses if the state was CMD, DATA or CSUM. The shadow register keeps its value.
- **Shadow register.** Inputs that change during a frame do not affect the frame in progress; the snapshot is taken only at command decode.
- **`sck` edges while `ss` is high** are ignored.

## Timing

- Synchronizer plus edge-detect latency is 3 `clock` cycles from a pin edge to the internal edge pulse.
- **First `miso` bit:** valid 3 cycles after `ss` falls, so the master must allow at least 4 cycles before the first `sck` rise.
- **`miso` update:** 4 cycles after each `sck` fall pin edge, which is within the half period at `clock`/8.
- `frame_done` asserts 4 cycles after the last `sck` rise of the final byte.
- `cmd_err` asserts 4 cycles after the 8th `sck` rise of the command byte.
- **Reset values:**
  - Outputs: `miso`=0, `miso_oe`=0, `busy`=0, `frame_done`=0, `cmd_err`=0, `frame_abort`=0.
  - Internal: state=IDLE, shadow=0.
  - Synchronizer flops reset to `ss`=1, `sck`=0, `mosi`=0, so no false edge is seen at reset release.
- **Reset mid-frame:** outputs take their reset values immediately (asynchronous). After reset releases, a new frame requires a fresh `ss` falling edge.
- **Simultaneous `ss` rise and `sck` rise in the same cycle:** the `ss` rise wins; the RX byte is discarded.

## Configuration

- `IMU_RESP_CHECKSUM_EN` defined:
  - After byte 17, the CSUM state sends one more byte: the XOR of the 18 data bytes.
  - `frame_done` pulses after that 19th byte.
  - `ss` rise during CSUM causes `frame_abort`.
- `IMU_RESP_CHECKSUM_EN` undefined: the CSUM state and the XOR accumulator are not built, and the frame is 18 bytes.

## Test plan

- **Normal frame:** roll=16'h1234, pitch=16'h5678, … accel_z=16'hBEEF; master sends 8'h01 followed by 18 dummy bytes at `clock`/8.
  - Required: bytes received are 8'hA5, 8'h12, 8'h34, 8'h56, 8'h78 … 8'hBE, 8'hEF.
  - Required: one `frame_done` pulse.
- **Bad command:** master sends 8'h7E and 3 further bytes.
  - Required: 8'hA5, then 8'h00 ×3.
  - Required: `cmd_err` pulses once; `frame_done` never pulses.
- **Abort:** `ss` rises after data byte 5.
  - Required: `frame_abort` pulses and `busy`→0.
  - Required: the next frame starts again at roll high byte.
- **Snapshot:** change roll to 16'hFFFF during byte 3 of a frame.
  - Required: the current frame still returns 16'h1234; the next frame returns 16'hFFFF.
- **Checksum build:** with the normal-frame inputs.
  - Required: the 19th byte equals the XOR of the 18 data bytes, and `frame_done` follows the 19th byte.
- **Reset:** pull `reset` low mid-byte.
  - Required: all outputs clear in the same cycle.
  - Required: a subsequent complete frame is correct.

Source files
------------

// File: rtl/imu_spi_responder.sv
// imu_spi_responder: SPI mode-0 slave standing in for the IMU on the jb_imu link.
// Answers the frame-read command with nine 16-bit words snapshotted from the
// parallel inputs, high byte first. All SPI pins are oversampled on clock.
// Optional feature: define IMU_RESP_CHECKSUM_EN to append an XOR checksum byte.
`timescale 1ns/1ps

module imu_spi_responder (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] roll,
    input  logic [15:0] pitch,
    input  logic [15:0] yaw,
    input  logic [15:0] roll_rate,
    input  logic [15:0] pitch_rate,
    input  logic [15:0] yaw_rate,
    input  logic [15:0] accel_x,
    input  logic [15:0] accel_y,
    input  logic [15:0] accel_z,
    input  logic        ss,
    input  logic        sck,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    output logic        busy,
    output logic        frame_done,
    output logic        cmd_err,
    output logic        frame_abort
);

    localparam logic [7:0] READ_CMD  = 8'h01;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [4:0] LAST_DATA = 5'd17;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_DATA  = 3'd2,
`ifdef IMU_RESP_CHECKSUM_EN
        ST_CSUM  = 3'd3,
`endif
        ST_DRAIN = 3'd4
    } state_t;

    // Synchronizer chains: meta, sync, and a history flop for edge detection
    logic ss_meta_q, ss_sync_q, ss_hist_q;
    logic sck_meta_q, sck_sync_q, sck_hist_q;
    logic mosi_meta_q, mosi_sync_q, mosi_hist_q;
    logic sck_rise_q, sck_rise_d;
    logic sck_fall_q, sck_fall_d;
    logic ss_rise, ss_fall;

    state_t       state_q, state_d;
    logic [2:0]   bit_cnt_q, bit_cnt_d;
    logic [4:0]   byte_cnt_q, byte_cnt_d;
    logic [6:0]   rx_q, rx_d;
    logic [7:0]   rx_shift;
    logic [7:0]   tx_q, tx_d;
    logic         miso_q, miso_d;
    logic [143:0] shadow_q, shadow_d;
    logic [143:0] live_words;
    logic [7:0]   next_byte;
    logic         frame_done_q, frame_done_d;
    logic         cmd_err_q, cmd_err_d;
    logic         frame_abort_q, frame_abort_d;
`ifdef IMU_RESP_CHECKSUM_EN
    logic [7:0]   csum_q, csum_d;
`endif

    // Picks byte idx (0 = roll high byte) out of the packed nine-word frame
    function automatic logic [7:0] byte_of(input logic [143:0] words, input logic [4:0] idx);
        logic [143:0] shifted;
        shifted = words >> (8 * (LAST_DATA - idx));
        return shifted[7:0];
    endfunction

    assign live_words = {roll, pitch, yaw, roll_rate, pitch_rate, yaw_rate,
                         accel_x, accel_y, accel_z};

    // Resets to idle pin levels (ss high, sck/mosi low) so release shows no edge
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ss_meta_q   <= 1'b1;
            ss_sync_q   <= 1'b1;
            ss_hist_q   <= 1'b1;
            sck_meta_q  <= 1'b0;
            sck_sync_q  <= 1'b0;
            sck_hist_q  <= 1'b0;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
            mosi_hist_q <= 1'b0;
            sck_rise_q  <= 1'b0;
            sck_fall_q  <= 1'b0;
        end else begin
            ss_meta_q   <= ss;
            ss_sync_q   <= ss_meta_q;
            ss_hist_q   <= ss_sync_q;
            sck_meta_q  <= sck;
            sck_sync_q  <= sck_meta_q;
            sck_hist_q  <= sck_sync_q;
            mosi_meta_q <= mosi;
            mosi_sync_q <= mosi_meta_q;
            mosi_hist_q <= mosi_sync_q;
            sck_rise_q  <= sck_rise_d;
            sck_fall_q  <= sck_fall_d;
        end
    end

    // Edge detection; sck edges are registered so mosi_hist lines up with them
    always_comb begin
        sck_rise_d = sck_sync_q & ~sck_hist_q;
        sck_fall_d = ~sck_sync_q & sck_hist_q;
        ss_rise    = ss_sync_q & ~ss_hist_q;
        ss_fall    = ~ss_sync_q & ss_hist_q;
    end

    // Frame state register and datapath flops
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= 3'd0;
            byte_cnt_q    <= 5'd0;
            rx_q          <= 7'd0;
            tx_q          <= 8'd0;
            miso_q        <= 1'b0;
            shadow_q      <= '0;
            frame_done_q  <= 1'b0;
            cmd_err_q     <= 1'b0;
            frame_abort_q <= 1'b0;
`ifdef IMU_RESP_CHECKSUM_EN
            csum_q        <= 8'd0;
`endif
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            rx_q          <= rx_d;
            tx_q          <= tx_d;
            miso_q        <= miso_d;
            shadow_q      <= shadow_d;
            frame_done_q  <= frame_done_d;
            cmd_err_q     <= cmd_err_d;
            frame_abort_q <= frame_abort_d;
`ifdef IMU_RESP_CHECKSUM_EN
            csum_q        <= csum_d;
`endif
        end
    end

    // Next-state and shifting logic; an ss rise overrides any same-cycle sck edge
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        byte_cnt_d    = byte_cnt_q;
        rx_d          = rx_q;
        tx_d          = tx_q;
        miso_d        = miso_q;
        shadow_d      = shadow_q;
        frame_done_d  = 1'b0;
        cmd_err_d     = 1'b0;
        frame_abort_d = 1'b0;
        rx_shift      = {rx_q, mosi_hist_q};
        next_byte     = byte_of(shadow_q, byte_cnt_q + 5'd1);
`ifdef IMU_RESP_CHECKSUM_EN
        csum_d        = csum_q;
`endif

        if (ss_rise) begin
            state_d       = ST_IDLE;
            bit_cnt_d     = 3'd0;
            byte_cnt_d    = 5'd0;
            miso_d        = 1'b0;
            frame_abort_d = (state_q != ST_IDLE) && (state_q != ST_DRAIN);
        end else if (state_q == ST_IDLE) begin
            miso_d = 1'b0;
            if (ss_fall) begin
                bit_cnt_d = 3'd0;
                tx_d      = SYNC_BYTE;
                miso_d    = SYNC_BYTE[7];
                state_d   = ST_CMD;
            end
        end else begin
            // A fall right after a byte boundary presents the freshly loaded MSB
            if (sck_fall_q) begin
                if (bit_cnt_q == 3'd0) begin
                    miso_d = tx_q[7];
                end else begin
                    tx_d   = {tx_q[6:0], 1'b0};
                    miso_d = tx_q[6];
                end
            end
            if (sck_rise_q) begin
                if (state_q != ST_DRAIN) begin
                    rx_d = rx_shift[6:0];
                end
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    case (state_q)
                        ST_CMD: begin
                            if (rx_shift == READ_CMD) begin
                                shadow_d   = live_words;
                                byte_cnt_d = 5'd0;
                                tx_d       = live_words[143:136];
`ifdef IMU_RESP_CHECKSUM_EN
                                csum_d     = live_words[143:136];
`endif
                                state_d    = ST_DATA;
                            end else begin
                                cmd_err_d = 1'b1;
                                tx_d      = 8'h00;
                                state_d   = ST_DRAIN;
                            end
                        end
                        ST_DATA: begin
                            if (byte_cnt_q == LAST_DATA) begin
`ifdef IMU_RESP_CHECKSUM_EN
                                tx_d    = csum_q;
                                state_d = ST_CSUM;
`else
                                frame_done_d = 1'b1;
                                tx_d         = 8'h00;
                                state_d      = ST_DRAIN;
`endif
                            end else begin
                                byte_cnt_d = byte_cnt_q + 5'd1;
                                tx_d       = next_byte;
`ifdef IMU_RESP_CHECKSUM_EN
                                csum_d     = csum_q ^ next_byte;
`endif
                            end
                        end
`ifdef IMU_RESP_CHECKSUM_EN
                        ST_CSUM: begin
                            frame_done_d = 1'b1;
                            tx_d         = 8'h00;
                            state_d      = ST_DRAIN;
                        end
`endif
                        default: begin
                            tx_d = 8'h00;
                        end
                    endcase
                end
            end
        end
    end

    assign miso        = miso_q;
    assign miso_oe     = ~ss_sync_q;
    assign busy        = (state_q != ST_IDLE);
    assign frame_done  = frame_done_q;
    assign cmd_err     = cmd_err_q;
    assign frame_abort = frame_abort_q;

endmodule
